// File: rtl/aes_sbox_pipe_if.sv
// -----------------------------------------------------------------------------
// aes_sbox_pipe_if
//   Stream bundle for the pipelined multi-lane AES S-box.
//   Producer (master) drives in_valid / in_data / in_inv and out_ready.
//   The S-box (slave) drives in_ready, out_valid, out_data and busy.
// Signals
//   in_valid   input beat valid
//   in_ready   block can accept a beat this cycle
//   in_data    8*LANES bits, byte k = in_data[8k+7:8k]
//   in_inv     1 = inverse S-box for this beat (only honoured with AES_INV_SBOX_EN)
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_data   substituted bytes, same lane order as the input
//   busy       any pipeline stage holds a beat
// -----------------------------------------------------------------------------
interface aes_sbox_pipe_if #(
   parameter int LANES = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [8*LANES-1:0]   in_data;
   logic                 in_inv;
   logic                 out_valid;
   logic                 out_ready;
   logic [8*LANES-1:0]   out_data;
   logic                 busy;

   modport master (
      output in_valid, in_data, in_inv, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_inv, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/aes_sbox_pipe.sv
// -----------------------------------------------------------------------------
// aes_sbox_pipe
//   Multi-lane pipelined AES S-box. Every lane computes the GF(2^8)
//   multiplicative inverse (poly 0x11B) followed by the AES affine transform.
//   Valid/ready stream, one beat per cycle, lossless stalls with bubble
//   collapsing.
// Parameters
//   LANES   byte lanes per beat (1..16), data width 8*LANES
//   REG_IN  1: register after the inversion (latency 2), 0: single stage (latency 1)
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset, discards every in-flight beat
//   s     aes_sbox_pipe_if.slave stream bundle (in_*, out_*, busy)
// Configuration
//   AES_INV_SBOX_EN  when defined, in_inv=1 selects the inverse S-box
//                    y = inv(iaff(x)); the per-beat flag travels with its beat.
//                    When undefined, in_inv is ignored and no flag logic exists.
// -----------------------------------------------------------------------------
module aes_sbox_pipe #(
   parameter int LANES  = 4,
   parameter bit REG_IN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   aes_sbox_pipe_if.slave   s
);
   localparam int         W      = 8 * LANES;
   localparam logic [7:0] AFF_C  = 8'h63;
   localparam logic [7:0] IAFF_D = 8'h05;

   // GF(2^8) multiply, reduction polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
      end
      return acc;
   endfunction

   // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero naturally
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = x;
      acc = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   // Forward affine; 3-bit casts give the mod-8 bit indexing
   function automatic logic [7:0] aff(input logic [7:0] x);
      logic [7:0] y;
      y = 8'h00;
      for (int i = 0; i < 8; i++) begin
         y[3'(i)] = x[3'(i)] ^ x[3'(i + 4)] ^ x[3'(i + 5)] ^ x[3'(i + 6)]
                  ^ x[3'(i + 7)] ^ AFF_C[3'(i)];
      end
      return y;
   endfunction

`ifdef AES_INV_SBOX_EN
   // Inverse affine, applied ahead of the inversion for inverse beats
   function automatic logic [7:0] iaff(input logic [7:0] x);
      logic [7:0] y;
      y = 8'h00;
      for (int i = 0; i < 8; i++) begin
         y[3'(i)] = x[3'(i + 2)] ^ x[3'(i + 5)] ^ x[3'(i + 7)] ^ IAFF_D[3'(i)];
      end
      return y;
   endfunction
`endif

   logic [W-1:0] w_inv_data;      // inverted bytes of the incoming beat
   logic [W-1:0] w_s2_src_data;   // inverted bytes feeding the output stage
   logic [W-1:0] w_s2_next;       // final bytes to load into S2
   logic         w_s2_src_valid;
   logic         w_s2_src_inv;
   logic         w_s2_load;
   logic         w_first_load;
   logic         w_s1_valid;

   logic         r_s2_valid;
   logic [W-1:0] r_s2_data;

   // Per-lane datapath; lanes share no state
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [7:0] w_pre_byte;
         logic [7:0] w_src_byte;
`ifdef AES_INV_SBOX_EN
         assign w_pre_byte = s.in_inv ? iaff(s.in_data[8*gi +: 8]) : s.in_data[8*gi +: 8];
`else
         assign w_pre_byte = s.in_data[8*gi +: 8];
`endif
         assign w_inv_data[8*gi +: 8] = gf_inv(w_pre_byte);
         assign w_src_byte            = w_s2_src_data[8*gi +: 8];
         // Inverse beats skip the output affine
         assign w_s2_next[8*gi +: 8]  = w_s2_src_inv ? w_src_byte : aff(w_src_byte);
      end
   endgenerate

   // S2 advances whenever it is empty or its beat is being taken
   assign w_s2_load = !r_s2_valid || s.out_ready;

   generate
      if (REG_IN) begin : g_s1
         logic         r_s1_valid;
         logic [W-1:0] r_s1_data;
         logic         w_s1_load;

         // Bubble collapse: an empty S1 loads even while S2 is stalled
         assign w_s1_load = !r_s1_valid || w_s2_load;

`ifdef AES_INV_SBOX_EN
         logic r_s1_inv;
         always_ff @(posedge clk) begin
            if (rst) begin
               r_s1_inv <= 1'b0;
            end else if (w_s1_load && s.in_valid) begin
               r_s1_inv <= s.in_inv;
            end
         end
         assign w_s2_src_inv = r_s1_inv;
`endif

         always_ff @(posedge clk) begin
            if (rst) begin
               r_s1_valid <= 1'b0;
               r_s1_data  <= '0;
            end else if (w_s1_load) begin
               r_s1_valid <= s.in_valid;
               if (s.in_valid) begin
                  r_s1_data <= w_inv_data;
               end
            end
         end

         assign w_s2_src_valid = r_s1_valid;
         assign w_s2_src_data  = r_s1_data;
         assign w_first_load   = w_s1_load;
         assign w_s1_valid     = r_s1_valid;
      end else begin : g_no_s1
`ifdef AES_INV_SBOX_EN
         assign w_s2_src_inv = s.in_inv;
`endif
         assign w_s2_src_valid = s.in_valid;
         assign w_s2_src_data  = w_inv_data;
         assign w_first_load   = w_s2_load;
         assign w_s1_valid     = 1'b0;
      end
   endgenerate

`ifndef AES_INV_SBOX_EN
   assign w_s2_src_inv = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
      end else if (w_s2_load) begin
         r_s2_valid <= w_s2_src_valid;
         if (w_s2_src_valid) begin
            r_s2_data <= w_s2_next;
         end
      end
   end

   // in_ready depends only on stage valids and out_ready, never on in_valid
   assign s.in_ready  = w_first_load;
   assign s.out_valid = r_s2_valid;
   assign s.out_data  = r_s2_data;
   assign s.busy      = r_s2_valid | w_s1_valid;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// -----------------------------------------------------------------------------
// tb_aes_sbox_pipe
//   Self-checking bench for aes_sbox_pipe (LANES=4). Reference S-box tables
//   are built from field arithmetic by brute-force inverse search; a
//   scoreboard follows every transfer. Honors AES_INV_SBOX_EN when defined.
// -----------------------------------------------------------------------------
module tb_aes_sbox_pipe;
   localparam int LANES  = 4;
   localparam bit REG_IN = 1'b1;
   localparam int W      = 8 * LANES;
   localparam int LAT    = int'(REG_IN) + 1;

   logic clk;
   logic rst;
   aes_sbox_pipe_if #(.LANES(LANES)) bus ();

   aes_sbox_pipe #(.LANES(LANES), .REG_IN(REG_IN)) dut (
      .clk (clk),
      .rst (rst),
      .s   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   logic [7:0] sbox  [256];
   logic [7:0] isbox [256];

   logic [W-1:0] sb_q    [$];
   logic [W-1:0] tx_data [$];
   logic         tx_inv  [$];
   logic [W-1:0] tx_exp  [$];
   logic [W-1:0] rx      [$];
   int           rx_cyc  [$];

   typedef struct {
      logic [W-1:0] din;
      logic         inv;
      logic [W-1:0] dout;
   } vec_t;
   vec_t vecs [6];

   // ---------------- reference model ----------------
   function automatic int m_mul(input int a, input int b);
      int p;
      p = 0;
      for (int k = 0; k < 8; k++) begin
         if (((b >> k) & 1) != 0) p = p ^ a;
         a = a << 1;
         if ((a & 'h100) != 0) a = a ^ 'h11B;
      end
      return p & 'hFF;
   endfunction

   function automatic int m_rotl(input int x, input int n);
      return ((x << n) | (x >> (8 - n))) & 'hFF;
   endfunction

   task automatic build_tables();
      int minv [256];
      int t;
      for (int x = 0; x < 256; x++) begin
         minv[x] = 0;
         for (int y = 1; y < 256; y++)
            if (x != 0 && m_mul(x, y) == 1) minv[x] = y;
      end
      for (int x = 0; x < 256; x++) begin
         t = minv[x];
         sbox[x] = 8'(t ^ m_rotl(t, 1) ^ m_rotl(t, 2) ^ m_rotl(t, 3) ^ m_rotl(t, 4) ^ 'h63);
         t = m_rotl(x, 1) ^ m_rotl(x, 3) ^ m_rotl(x, 6) ^ 'h05;
         isbox[x] = 8'(minv[t]);
      end
   endtask

   function automatic logic [W-1:0] ref_word(input logic [W-1:0] d, input logic inv);
      logic [W-1:0] r;
      logic use_inv;
`ifdef AES_INV_SBOX_EN
      use_inv = inv;
`else
      use_inv = 1'b0 & inv;
`endif
      r = '0;
      for (int k = 0; k < LANES; k++)
         r[8*k +: 8] = use_inv ? isbox[d[8*k +: 8]] : sbox[d[8*k +: 8]];
      return r;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: one record per transfer, sampled on the falling edge
   always @(negedge clk) begin
      if (mon_en) begin
         if (rst) begin
            sb_q.delete();
         end else begin
            check("busy_vs_model", W'(bus.busy), W'(sb_q.size() != 0));
            if (bus.out_valid && bus.out_ready) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got %h expected no beat", bus.out_data);
               end else begin
                  check("scoreboard", bus.out_data, sb_q.pop_front());
               end
            end
            if (bus.in_valid && bus.in_ready)
               sb_q.push_back(ref_word(bus.in_data, bus.in_inv));
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 50) begin
         tick();
         n++;
      end
      check("idle_reached", W'(n < 50), W'(1));
   endtask

   task automatic single_beat(input logic [W-1:0] din, input logic inv,
                              input logic [W-1:0] exp, input string name);
      int n;
      wait_idle();
      n = 0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = din;
      bus.in_inv    = inv;
      do begin
         tick();
         n++;
         if (n == 1) bus.in_valid = 1'b0;
      end while (!bus.out_valid && n < 10);
      check({name, "_lat"}, W'(n), W'(LAT));
      check({name, "_data"}, bus.out_data, exp);
      $display("beat %s: in=%h inv=%0d out=%h latency=%0d", name, din, inv, bus.out_data, n);
      tick();
   endtask

   // Drives tx_data in order honouring in_ready; collects accepted outputs.
   task automatic run_stream(input bit rnd, input int stall_at, input int stall_len,
                             input int budget, output int n_low);
      int idx;
      int cyc;
      bit acc;
      bit prev_stall;
      logic [W-1:0] held;
      idx = 0; cyc = 0; n_low = 0; prev_stall = 1'b0; held = '0;
      rx.delete();
      rx_cyc.delete();
      while ((idx < tx_data.size() || bus.busy) && cyc < budget) begin
         if (idx < tx_data.size() && (!rnd || $urandom_range(0, 3) != 0)) begin
            bus.in_valid = 1'b1;
            bus.in_data  = tx_data[idx];
            bus.in_inv   = tx_inv[idx];
         end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = W'($urandom);
            bus.in_inv   = 1'($urandom_range(0, 1));
         end
         if (rnd) bus.out_ready = ($urandom_range(0, 2) != 0);
         else     bus.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
         #1;
         if (prev_stall) begin
            check("hold_valid", W'(bus.out_valid), W'(1));
            check("hold_data", bus.out_data, held);
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         held = bus.out_data;
         if (!bus.in_ready) n_low++;
         if (bus.out_valid && bus.out_ready) begin
            rx.push_back(bus.out_data);
            rx_cyc.push_back(cyc);
         end
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) idx++;
         cyc++;
      end
      check("stream_done", W'(cyc < budget), W'(1));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   task automatic load_random(input int n, input bit rnd_inv);
      tx_data.delete(); tx_inv.delete(); tx_exp.delete();
      for (int k = 0; k < n; k++) begin
         tx_data.push_back(W'($urandom));
         tx_inv.push_back(rnd_inv ? 1'($urandom_range(0, 1)) : 1'b0);
         tx_exp.push_back(ref_word(tx_data[k], tx_inv[k]));
      end
   endtask

   task automatic compare_rx(input string name);
      check({name, "_count"}, W'(rx.size()), W'(tx_exp.size()));
      for (int k = 0; k < tx_exp.size() && k < rx.size(); k++)
         check({name, "_order"}, rx[k], tx_exp[k]);
      $display("stream %s: sent=%0d received=%0d", name, tx_exp.size(), rx.size());
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n_low;
      logic [W-1:0] exp5 [4];

      build_tables();
      vecs[0] = '{32'hFF53_0100, 1'b0, 32'h16ED_7C63};
      vecs[1] = '{32'h0000_0000, 1'b0, 32'h6363_6363};
      vecs[2] = '{32'h1020_4080, 1'b0, 32'hCAB7_09CD};
      vecs[3] = '{32'h0102_0304, 1'b0, 32'h7C77_7BF2};
`ifdef AES_INV_SBOX_EN
      vecs[4] = '{32'h16ED_7C63, 1'b1, 32'hFF53_0100};
      vecs[5] = '{32'h6363_6363, 1'b1, 32'h0000_0000};
`else
      vecs[4] = '{32'h16ED_7C63, 1'b1, 32'h4755_10FB};
      vecs[5] = '{32'h6363_6363, 1'b1, 32'hFBFB_FBFB};
`endif

      // Reset held 3 cycles with in_valid asserted
      rst = 1'b1;
      bus.in_valid = 1'b1; bus.in_data = 32'hFF53_0100; bus.in_inv = 1'b0; bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("rst_out_valid", W'(bus.out_valid), W'(0));
         check("rst_busy", W'(bus.busy), W'(0));
      end
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check("post_rst_in_ready", W'(bus.in_ready), W'(1));
      check("post_rst_out_data", bus.out_data, '0);
      $display("reset: out_valid=%0d busy=%0d in_ready=%0d", bus.out_valid, bus.busy, bus.in_ready);
      mon_en = 1'b1;

      // Table vectors with latency
      for (int v = 0; v < 6; v++)
         single_beat(vecs[v].din, vecs[v].inv, vecs[v].dout, $sformatf("vec%0d", v));

      // 8 back-to-back beats, no backpressure
      load_random(8, 1'b0);
      run_stream(1'b0, 1000, 0, 100, n_low);
      check("b2b_in_ready_low", W'(n_low), W'(0));
      check("b2b_contiguous", W'(rx_cyc[7] - rx_cyc[0]), W'(7));
      compare_rx("b2b");

      // 5-cycle backpressure mid-stream
      load_random(10, 1'b0);
      run_stream(1'b0, 3, 5, 100, n_low);
      check("bp_in_ready_dropped", W'(n_low > 0), W'(1));
      compare_rx("bp");

`ifdef AES_INV_SBOX_EN
      // Mixed forward/inverse beats back to back
      tx_data.delete(); tx_inv.delete(); tx_exp.delete();
      exp5[0] = 32'hFF53_0100; exp5[1] = 32'h16ED_7C63;
      exp5[2] = 32'hFF53_0100; exp5[3] = 32'h16ED_7C63;
      for (int k = 0; k < 4; k++) begin
         tx_data.push_back(k[0] ? 32'hFF53_0100 : 32'h16ED_7C63);
         tx_inv.push_back(!k[0]);
         tx_exp.push_back(exp5[k]);
      end
      run_stream(1'b0, 1000, 0, 100, n_low);
      compare_rx("mixed");
`else
      exp5[0] = '0;
      exp5[1] = exp5[0];
`endif

      // Randomised traffic against the scoreboard
      load_random(150, 1'b1);
      run_stream(1'b1, 0, 0, 3000, n_low);
      compare_rx("random");

      // Reset with two beats in flight
      wait_idle();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 32'h0102_0304; bus.in_inv = 1'b0;
      tick();
      bus.in_data = 32'h1020_4080;
      tick();
      bus.in_valid = 1'b0;
      check("inflight_busy", W'(bus.busy), W'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_out_valid", W'(bus.out_valid), W'(0));
      check("midrst_busy", W'(bus.busy), W'(0));
      check("midrst_in_ready", W'(bus.in_ready), W'(1));
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("midrst_no_beat", W'(bus.out_valid), W'(0));
      end
      single_beat(32'h0000_0000, 1'b0, 32'h6363_6363, "post_midrst");

      wait_idle();
      tick();
      check("scoreboard_drained", W'(sb_q.size()), W'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
